// File: rtl/barrett_correct_ctrl_pkg.sv
// Shared definitions for the Barrett correction sequencer: state encoding and default widths.
package barrett_correct_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int N_DEF       = 8;
  localparam int W_DEF       = N_DEF + 2;
  localparam int MAX_SUB_DEF = 2;

endpackage

// File: rtl/barrett_correct_ctrl_rca.sv
// Ripple-carry adder shared by every subtraction step of the correction sequencer.
module barrett_correct_ctrl_rca #(
  parameter int n = 10
) (
  input  logic [n-1:0] a_i,
  input  logic [n-1:0] b_i,
  input  logic         c_i,
  output logic [n-1:0] sum_o,
  output logic         c_o
);

  logic [n:0] carry;

  always_comb begin
    carry    = '0;
    sum_o    = '0;
    carry[0] = c_i;
    for (int i = 0; i < n; i++) begin
      sum_o[i]   = a_i[i] ^ b_i[i] ^ carry[i];
      carry[i+1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end
    c_o = carry[n];
  end

endmodule

// File: rtl/barrett_correct_ctrl.sv
// Final Barrett correction: subtracts m from r, one adder pass per cycle, until r < m
// or MAX_SUB subtractions have been spent (then flags error).
//
// state | meaning
// IDLE  | ready for a new remainder; start accepted here only
// SUB   | one compare/subtract per cycle through the shared adder
// DONE  | done pulse; result and error are valid
module barrett_correct_ctrl
  import barrett_correct_ctrl_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = N + 2,
  parameter int MAX_SUB = MAX_SUB_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] r_in,
  input  logic [N-1:0] m_in,
  output logic         ready,
  output logic         done,
  output logic         error,
  output logic [N-1:0] result
);

  localparam int CNT_W = (MAX_SUB > 0) ? $clog2(MAX_SUB + 1) : 1;

  state_e           state_q, state_d;
  logic [W-1:0]     r_q, r_d;
  logic [W-1:0]     m_q, m_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     res_q, res_d;
  logic             err_q, err_d;

  logic [W-1:0]     sum;
  logic             c_out;

  // Carry-out of r + ~m + 1 is the r >= m compare; sum is the difference.
  barrett_correct_ctrl_rca #(.n(W)) u_rca (
    .a_i   (r_q),
    .b_i   (~m_q),
    .c_i   (1'b1),
    .sum_o (sum),
    .c_o   (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d     = r_in;
          m_d     = {{(W-N){1'b0}}, m_in};
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        if (!c_out) begin
          res_d   = r_q[N-1:0];
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_W'(MAX_SUB)) begin
          // Budget exhausted with r still >= m: deliver the truncated value, flagged.
          res_d   = r_q[N-1:0];
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          r_d   = sum;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign error  = err_q;
  assign result = res_q;

endmodule

// File: tb/tb_barrett_correct_ctrl.sv
// Self-checking bench: directed table, hand-written busy/reset sequences, and random
// operations checked against an arithmetic reference of the correction rule.
module tb_barrett_correct_ctrl;

  localparam int N       = 8;
  localparam int W       = 10;
  localparam int MAX_SUB = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] r_in = '0;
  logic [N-1:0] m_in = '0;
  logic         ready, done, error;
  logic [N-1:0] result;

  int tests = 0;
  int fails = 0;

  barrett_correct_ctrl #(.N(N), .W(W), .MAX_SUB(MAX_SUB)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .r_in   (r_in),
    .m_in   (m_in),
    .ready  (ready),
    .done   (done),
    .error  (error),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int m;
    int exp_res;
    int exp_err;
    int exp_lat;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: subtract while r >= m and budget remains; still >= m means error.
  task automatic model(input int r, input int m, output int res, output int err, output int lat);
    int k = 0;
    int v = r;
    while (v >= m && k < MAX_SUB) begin
      v = v - m;
      k++;
    end
    if (v >= m) begin
      err = 1;
      lat = 2 + MAX_SUB;
    end else begin
      err = 0;
      lat = 2 + k;
    end
    res = v % 256;
  endtask

  int rdy_log[0:31];
  int rdy_after, done_after, res_after, err_after;

  // Starts one operation (accepted at edge T) and returns what is seen when done rises.
  // lat = n means done observed in cycle T+n; 99 means it never came.
  task automatic run_op(input int r, input int m, input bit poke,
                        output int res, output int err, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    r_in  = W'(r);
    m_in  = N'(m);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    r_in  = W'($urandom);
    m_in  = N'($urandom);
    if (poke) begin
      start = 1'b1;
      r_in  = W'(10);
    end
    lat = 1;
    res = -1;
    err = -1;
    while (lat < 20) begin
      @(negedge clk);
      start = 1'b0;
      rdy_log[lat] = int'(ready);
      if (done) break;
      lat++;
    end
    if (lat >= 20) begin
      lat = 99;
    end else begin
      res = int'(result);
      err = int'(error);
    end
    @(negedge clk);
    rdy_after  = int'(ready);
    done_after = int'(done);
    res_after  = int'(result);
    err_after  = int'(error);
  endtask

  vec_t vecs[6];

  initial begin
    int res, err, lat;
    int er, ee, el;
    bit saw_done;

    vecs[0] = '{r: 50,  m: 97, exp_res: 50, exp_err: 0, exp_lat: 2};
    vecs[1] = '{r: 150, m: 97, exp_res: 53, exp_err: 0, exp_lat: 3};
    vecs[2] = '{r: 290, m: 97, exp_res: 96, exp_err: 0, exp_lat: 4};
    vecs[3] = '{r: 97,  m: 97, exp_res: 0,  exp_err: 0, exp_lat: 3};
    vecs[4] = '{r: 291, m: 97, exp_res: 97, exp_err: 1, exp_lat: 4};
    vecs[5] = '{r: 5,   m: 0,  exp_res: 5,  exp_err: 1, exp_lat: 4};

    repeat (2) @(negedge clk);
    check("reset_ready", int'(ready), 1);
    check("reset_done", int'(done), 0);
    check("reset_error", int'(error), 0);
    check("reset_result", int'(result), 0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].r, vecs[i].m, 1'b0, res, err, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      check($sformatf("vec%0d_error", i), err, vecs[i].exp_err);
      check($sformatf("vec%0d_done_pulse", i), done_after, 0);
      check($sformatf("vec%0d_result_held", i), res_after, vecs[i].exp_res);
      if (i == 0) begin
        check("ready_low_T1", rdy_log[1], 0);
        check("ready_low_T2", rdy_log[2], 0);
        check("ready_high_T3", rdy_after, 1);
      end
    end

    // Start pulsed while busy must be ignored.
    run_op(290, 97, 1'b1, res, err, lat);
    check("busy_latency", lat, 4);
    check("busy_result", res, 96);
    check("busy_error", err, 0);

    // Reset in the middle of SUB aborts without a done pulse.
    @(negedge clk);
    r_in  = W'(290);
    m_in  = N'(97);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_ready", int'(ready), 1);
    check("abort_done", int'(done), 0);
    check("abort_result", int'(result), 0);
    check("abort_error", int'(error), 0);
    saw_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", int'(saw_done), 0);

    run_op(150, 97, 1'b0, res, err, lat);
    check("fresh_latency", lat, 3);
    check("fresh_result", res, 53);
    check("fresh_error", err, 0);

    for (int i = 0; i < 60; i++) begin
      int r, m;
      m = int'($urandom_range(0, 255));
      if (i % 4 == 0) r = int'($urandom_range(0, 1023));
      else r = int'($urandom_range(0, 3 * m + 2));
      if (r > 1023) r = 1023;
      model(r, m, er, ee, el);
      run_op(r, m, 1'b0, res, err, lat);
      check($sformatf("rand%0d_r%0d_m%0d_lat", i, r, m), lat, el);
      check($sformatf("rand%0d_r%0d_m%0d_res", i, r, m), res, er);
      check($sformatf("rand%0d_r%0d_m%0d_err", i, r, m), err, ee);
      check($sformatf("rand%0d_err_held", i), err_after, ee);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
